mem_stage_access_unit: RTL

MEM_STAGE_ACCESS_UNIT -- requirements
Module: mem_stage_access_unit

---
 rtl/mem_stage_access_unit_pkg.sv | 13 +
 rtl/mem_wait_timer.sv | 31 +++
 rtl/mem_stage_access_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/mem_stage_access_unit_pkg.sv
// rtl/mem_stage_access_unit_pkg.sv - shared pipeline types and widths for the MEM stage
package mem_stage_access_unit_pkg;

  localparam int DATA_W    = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } memState_t;

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts unanswered WAIT cycles and flags the abandon point
module mem_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  // The cycle whose increment would bring the count to MAX_WAIT is the last one allowed.
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  logic [CW-1:0] waitCount;

  // Clear on WAIT entry, count each WAIT cycle that ends without dmemReady.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waitCount <= '0;
    end else if (clear) begin
      waitCount <= '0;
    end else if (inc) begin
      waitCount <= waitCount + CW'(1);
    end
  end

  assign expire = inc && (waitCount == LAST);

endmodule

// File: rtl/mem_stage_access_unit.sv
// rtl/mem_stage_access_unit.sv - MEM stage data-memory access FSM with MEM/WB register
module mem_stage_access_unit
  import mem_stage_access_unit_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    memAluResult,
  input  logic [DATA_W-1:0]    memMemoryWriteData,
  input  logic [REG_IDX_W-1:0] memWriteRegisterIndex,
  input  logic                 memMemWrite,
  input  logic                 memMemToReg,
  input  logic                 memRegWrite,
  output logic                 dmemReq,
  output logic                 dmemWe,
  output logic [DATA_W-1:0]    dmemAddr,
  output logic [DATA_W-1:0]    dmemWdata,
  input  logic                 dmemReady,
  input  logic [DATA_W-1:0]    dmemRdata,
  output logic                 memStall,
  output logic [DATA_W-1:0]    wbWriteData,
  output logic [REG_IDX_W-1:0] wbWriteRegisterIndex,
  output logic                 wbRegWrite,
  output logic                 memTimeout
);

  memState_t         state;
  logic [DATA_W-1:0] loadData;
  logic              access;
  logic              isLoad;
  logic              timerClear;
  logic              timerInc;
  logic              timerExpire;

  // A store wins when both controls are set, so only a pure load selects loadData.
  assign access = memMemWrite | memMemToReg;
  assign isLoad = memMemToReg & ~memMemWrite;

  // DONE releases the stall even though the instruction is still an access,
  // which is what keeps the same instruction from being reissued.
  assign memStall   = (state == WAIT) || ((state == IDLE) && access);
  assign timerClear = (state == IDLE) && access;
  assign timerInc   = (state == WAIT) && !dmemReady;

  mem_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) uWaitTimer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timerClear),
    .inc    (timerInc),
    .expire (timerExpire)
  );

  // Access sequencer: issue in IDLE, hold the request in WAIT, retire in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      dmemReq    <= 1'b0;
      dmemWe     <= 1'b0;
      dmemAddr   <= '0;
      dmemWdata  <= '0;
      loadData   <= '0;
      memTimeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            dmemAddr  <= memAluResult;
            dmemWdata <= memMemoryWriteData;
            dmemWe    <= memMemWrite;
            dmemReq   <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (dmemReady) begin
            loadData <= dmemRdata;
            dmemReq  <= 1'b0;
            dmemWe   <= 1'b0;
            state    <= DONE;
          end else if (timerExpire) begin
            memTimeout <= 1'b1;
            loadData   <= '0;
            dmemReq    <= 1'b0;
            dmemWe     <= 1'b0;
            state      <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // MEM/WB register: advance when not stalled, otherwise insert a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbWriteData          <= '0;
      wbWriteRegisterIndex <= '0;
      wbRegWrite           <= 1'b0;
    end else if (!memStall) begin
      wbWriteData          <= isLoad ? loadData : memAluResult;
      wbWriteRegisterIndex <= memWriteRegisterIndex;
      wbRegWrite           <= memRegWrite;
    end else begin
      wbRegWrite <= 1'b0;
    end
  end

endmodule
